// File: rtl/sipo_rx_if.sv
// sipo_rx_if -- serial receive link bundle for sipo_rx.
//
// Purpose: groups the serial input side (s_in, s_valid, frame_start) and the
// parallel word output side (d_out, d_valid, busy, optional parity_err) of the
// receiver into one interface.
//
// Optional feature macro: SIPO_PARITY_EN adds the parity_err signal.
//
// Signals:
//   s_in         serial data bit                      (master -> slave)
//   s_valid      s_in carries a valid bit this cycle  (master -> slave)
//   frame_start  s_in is bit 0 of a new frame         (master -> slave)
//   d_out        last completed word                  (slave -> master)
//   d_valid      one-cycle strobe, d_out just updated (slave -> master)
//   busy         a frame is in progress               (slave -> master)
//   parity_err   parity of last word was wrong        (slave -> master, macro only)
//
// Modports: master = serial source / word consumer, slave = sipo_rx.

interface sipo_rx_if #(
    parameter int bits = 8
);
    logic            s_in;
    logic            s_valid;
    logic            frame_start;
    logic [bits-1:0] d_out;
    logic            d_valid;
    logic            busy;
`ifdef SIPO_PARITY_EN
    logic            parity_err;

    modport master (
        output s_in, s_valid, frame_start,
        input  d_out, d_valid, busy, parity_err
    );

    modport slave (
        input  s_in, s_valid, frame_start,
        output d_out, d_valid, busy, parity_err
    );
`else
    modport master (
        output s_in, s_valid, frame_start,
        input  d_out, d_valid, busy
    );

    modport slave (
        input  s_in, s_valid, frame_start,
        output d_out, d_valid, busy
    );
`endif
endinterface

// File: rtl/sipo_rx.sv
// sipo_rx -- serial-in/parallel-out receiver.
//
// Purpose: collects a framed serial bit stream into a `bits`-wide word and
// presents each completed word with a one-cycle d_valid strobe. Frames are
// aligned by frame_start; a bit counter and a small FSM track the position.
//
// Optional feature macro: SIPO_PARITY_EN -- each frame carries one extra even
// parity bit after the data bits, checked and reported on parity_err.
//
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   synchronous reset, active-high
//   sif   sipo_rx_if.slave: s_in, s_valid, frame_start in;
//         d_out, d_valid, busy (and parity_err with the macro) out
//
// Parameters:
//   bits       word width (>= 2)
//   MSB_FIRST  1: first received bit ends up in d_out[bits-1]; 0: in d_out[0]

module sipo_rx #(
    parameter int bits      = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    sipo_rx_if.slave     sif
);
    localparam int CNT_W = $clog2(bits + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(bits - 1);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [bits-1:0]  sreg, sreg_nxt, shifted;
    logic             deliver;
    logic             perr_nxt;

    // Shift one bit in, on the side that makes the first bit of a frame
    // end up at the word's configured end once all bits have arrived.
    function automatic logic [bits-1:0] shift_bit(input logic [bits-1:0] w,
                                                  input logic            b);
        if (MSB_FIRST)
            return {w[bits-2:0], b};
        else
            return {b, w[bits-1:1]};
    endfunction

    always_comb begin
        shifted   = shift_bit(sreg, sif.s_in);
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        deliver   = 1'b0;
        perr_nxt  = 1'b0;

        if (sif.s_valid) begin
            if (sif.frame_start) begin
                // A marker always (re)starts a frame, aborting any partial word.
                state_nxt = SHIFT;
                cnt_nxt   = CNT_W'(1);
                sreg_nxt  = shift_bit('0, sif.s_in);
            end else begin
                case (state)
                    SHIFT: begin
                        sreg_nxt = shifted;
                        if (cnt == LAST_DATA) begin
`ifdef SIPO_PARITY_EN
                            state_nxt = PARITY;
                            cnt_nxt   = CNT_W'(bits);
`else
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                            deliver   = 1'b1;
`endif
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
`ifdef SIPO_PARITY_EN
                    PARITY: begin
                        // Even parity: data bits XOR parity bit must be 0.
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        deliver   = 1'b1;
                        perr_nxt  = ^{sreg, sif.s_in};
                    end
`endif
                    default: begin
                        // IDLE: bits without a frame marker are ignored.
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            sreg           <= '0;
            sif.d_out      <= '0;
            sif.d_valid    <= 1'b0;
            sif.busy       <= 1'b0;
`ifdef SIPO_PARITY_EN
            sif.parity_err <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sreg        <= sreg_nxt;
            sif.d_valid <= deliver;
            // busy tracks the registered state exactly (same edge).
            sif.busy    <= (state_nxt != IDLE);
            if (deliver) begin
                sif.d_out      <= sreg_nxt;
`ifdef SIPO_PARITY_EN
                sif.parity_err <= perr_nxt;
`endif
            end
        end
    end

`ifndef SIPO_PARITY_EN
    // Parity result only has a consumer when the parity feature is built in.
    logic unused_perr;
    assign unused_perr = perr_nxt;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx -- self-checking bench for sipo_rx.
// Two receivers (MSB-first and LSB-first) see the same serial stream; their
// outputs are compared every cycle with a queue-based frame model, against a
// hand-derived vector table, and in directed corner-case sequences.

module tb_sipo_rx;
    localparam int BITS = 8;
`ifdef SIPO_PARITY_EN
    localparam int FRAME_LEN = BITS + 1;
`else
    localparam int FRAME_LEN = BITS;
`endif

    logic clk;
    logic rst;

    sipo_rx_if #(.bits(BITS)) if_m ();
    sipo_rx_if #(.bits(BITS)) if_l ();

    sipo_rx #(.bits(BITS), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .sif(if_m));
    sipo_rx #(.bits(BITS), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .sif(if_l));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int strobes_m = 0;
    int dv_cyc_l[$];

    // Reference model state: bits of the frame collected so far.
    logic       q[$];
    bit         in_frame = 0;
    logic [7:0] exp_m = '0, exp_l = '0;
    logic       exp_dv = 0, exp_busy = 0, exp_perr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_edge(input logic r, input logic sv, input logic fs, input logic si);
        logic [7:0] wm, wl;
        logic       par;
        if (r) begin
            q.delete();
            in_frame = 0;
            exp_m = '0; exp_l = '0; exp_dv = 0; exp_busy = 0; exp_perr = 0;
        end else begin
            exp_dv = 0;
            if (sv) begin
                if (fs) begin
                    q.delete();
                    q.push_back(si);
                    in_frame = 1;
                end else if (in_frame) begin
                    q.push_back(si);
                    if (q.size() == FRAME_LEN) begin
                        wm = '0; wl = '0; par = 0;
                        for (int i = 0; i < BITS; i++) begin
                            wm[BITS-1-i] = q[i];
                            wl[i]        = q[i];
                        end
                        for (int i = 0; i < FRAME_LEN; i++) par = par ^ q[i];
                        exp_m = wm; exp_l = wl; exp_perr = par; exp_dv = 1;
                        in_frame = 0;
                        q.delete();
                    end
                end
            end
            exp_busy = in_frame;
        end
    endtask

    // One clock: drive inputs, take the edge, update the model, compare at edge+1.
    task automatic step(input logic r, input logic sv, input logic fs, input logic si);
        rst = r;
        if_m.s_valid = sv; if_m.frame_start = fs; if_m.s_in = si;
        if_l.s_valid = sv; if_l.frame_start = fs; if_l.s_in = si;
        @(posedge clk);
        model_edge(r, sv, fs, si);
        #1;
        cyc++;
        check("m_d_out",   32'(if_m.d_out),   32'(exp_m));
        check("m_d_valid", 32'(if_m.d_valid), 32'(exp_dv));
        check("m_busy",    32'(if_m.busy),    32'(exp_busy));
        check("l_d_out",   32'(if_l.d_out),   32'(exp_l));
        check("l_d_valid", 32'(if_l.d_valid), 32'(exp_dv));
        check("l_busy",    32'(if_l.busy),    32'(exp_busy));
`ifdef SIPO_PARITY_EN
        check("m_parity_err", 32'(if_m.parity_err), 32'(exp_perr));
        check("l_parity_err", 32'(if_l.parity_err), 32'(exp_perr));
`endif
        if (if_m.d_valid === 1'b1) strobes_m++;
        if (if_l.d_valid === 1'b1) dv_cyc_l.push_back(cyc);
    endtask

    // Send one frame; the word's bits go out MSB-first or LSB-first, with
    // 3 idle cycles after bit number gap_a / gap_b (1-based, 0 = none).
    task automatic send_word(input logic [7:0] w, input bit msb, input int gap_a,
                             input int gap_b, input logic par);
        logic b;
        for (int i = 0; i < BITS; i++) begin
            b = msb ? w[BITS-1-i] : w[i];
            step(1'b0, 1'b1, (i == 0), b);
            if (i + 1 == gap_a || i + 1 == gap_b)
                repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
`ifdef SIPO_PARITY_EN
        step(1'b0, 1'b1, 1'b0, par);
`else
        if (par === 1'bx) $display("parity bit unused");
`endif
    endtask

    typedef struct {
        logic       r, sv, fs, si;
        logic       dv;
        logic [7:0] dm, dl;
        logic       busy;
    } vec_t;

    initial begin
        vec_t       tbl[$];
        logic [7:0] frame_bits;
        int         n0;
        logic [7:0] w;

        rst = 1'b1;
        if_m.s_valid = 0; if_m.frame_start = 0; if_m.s_in = 0;
        if_l.s_valid = 0; if_l.frame_start = 0; if_l.s_in = 0;

        // Reset, ignored idle bits, then the 1,1,0,0,1,0,1,1 frame:
        // MSB-first word 8'hCB, LSB-first word 8'hD3.
        tbl.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h00, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h00, 0});
        tbl.push_back('{0, 1, 0, 1, 0, 8'h00, 8'h00, 0});
        tbl.push_back('{0, 1, 0, 1, 0, 8'h00, 8'h00, 0});
        frame_bits = 8'hCB;
        for (int k = 0; k < BITS; k++) begin
            if (k == BITS - 1 && FRAME_LEN == BITS)
                tbl.push_back('{0, 1, 0, frame_bits[BITS-1-k], 1, 8'hCB, 8'hD3, 0});
            else
                tbl.push_back('{0, 1, (k == 0), frame_bits[BITS-1-k], 0, 8'h00, 8'h00, 1});
        end
        if (FRAME_LEN != BITS)
            tbl.push_back('{0, 1, 0, 1, 1, 8'hCB, 8'hD3, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 8'hCB, 8'hD3, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].sv, tbl[i].fs, tbl[i].si);
            check("tbl_d_valid", 32'(if_m.d_valid), 32'(tbl[i].dv));
            check("tbl_d_out_m", 32'(if_m.d_out),   32'(tbl[i].dm));
            check("tbl_d_out_l", 32'(if_l.d_out),   32'(tbl[i].dl));
            check("tbl_busy",    32'(if_m.busy),    32'(tbl[i].busy));
        end

        // Gapped frame: single strobe, no early one.
        n0 = strobes_m;
        send_word(8'hCB, 1, 2, 5, ^8'hCB);
        check("gap_d_out",   32'(if_m.d_out), 32'h00CB);
        check("gap_strobes", 32'(strobes_m - n0), 32'd1);
        step(0, 0, 0, 0);

        // Abort after 4 bits, restart with 8'hA5.
        n0 = strobes_m;
        for (int i = 0; i < 4; i++) step(0, 1, (i == 0), 1'($urandom));
        send_word(8'hA5, 1, 0, 0, ^8'hA5);
        check("abort_d_out",   32'(if_m.d_out), 32'h00A5);
        check("abort_strobes", 32'(strobes_m - n0), 32'd1);
        step(0, 0, 0, 0);

        // Reset after 5 bits: partial word discarded, no strobe.
        n0 = strobes_m;
        for (int i = 0; i < 5; i++) step(0, 1, (i == 0), 1'($urandom));
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1'($urandom));
        check("rst_strobes", 32'(strobes_m - n0), 32'd0);
        check("rst_d_out",   32'(if_m.d_out), 32'h0000);
        check("rst_busy",    32'(if_m.busy), 32'd0);

        // LSB-first back-to-back frames 8'hCB then 8'h3C.
        dv_cyc_l.delete();
        send_word(8'hCB, 0, 0, 0, ^8'hCB);
        check("b2b_first_d_out", 32'(if_l.d_out), 32'h00CB);
        send_word(8'h3C, 0, 0, 0, ^8'h3C);
        check("b2b_second_d_out", 32'(if_l.d_out), 32'h003C);
        check("b2b_strobes", 32'(dv_cyc_l.size()), 32'd2);
        if (dv_cyc_l.size() == 2)
            check("b2b_spacing", 32'(dv_cyc_l[1] - dv_cyc_l[0]), 32'(FRAME_LEN));
        step(0, 0, 0, 0);

`ifdef SIPO_PARITY_EN
        send_word(8'hCB, 1, 0, 0, 1'b1);
        check("par_ok_d_valid", 32'(if_m.d_valid), 32'd1);
        check("par_ok_err",     32'(if_m.parity_err), 32'd0);
        send_word(8'hCB, 1, 0, 0, 1'b0);
        check("par_bad_d_valid", 32'(if_m.d_valid), 32'd1);
        check("par_bad_err",     32'(if_m.parity_err), 32'd1);
        check("par_bad_d_out",   32'(if_m.d_out), 32'h00CB);
        step(0, 0, 0, 0);
`endif

        // Randomized traffic: whole frames, gaps, spurious markers, rare resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                w = 8'($urandom);
                send_word(w, 1'($urandom), $urandom_range(0, 8), $urandom_range(0, 8),
                          ($urandom_range(0, 3) == 0) ? ~^w : ^w);
            end else begin
                step(($urandom_range(0, 199) == 0),
                     ($urandom_range(0, 9) < 7),
                     ($urandom_range(0, 9) == 0),
                     1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
